// File: rtl/bp_pkg.sv
// Shared definitions for the branch target buffer: 2-bit direction counter
// encodings and their saturating update helpers.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    ctr_t r;
    case (c)
      SNT:     r = WNT;
      WNT:     r = WT;
      default: r = ST;
    endcase
    return r;
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    ctr_t r;
    case (c)
      ST:      r = WT;
      WT:      r = WNT;
      default: r = SNT;
    endcase
    return r;
  endfunction

  // A freshly allocated entry starts on the weak side of its first outcome.
  function automatic ctr_t ctr_init(input logic taken);
    return taken ? WT : WNT;
  endfunction

  function automatic logic ctr_taken(input ctr_t c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/branch_target_buffer_2bit_if.sv
// Fetch-side and execute-side signal bundle of the branch target buffer.
interface branch_target_buffer_2bit_if #(
  parameter int PC_W = 5
);
  logic [PC_W-1:0] F_pc;
  logic            F_stall;
  logic            MEM_stall;
  logic            EX_brn;
  logic [PC_W-1:0] EX_pc;
  logic [PC_W-1:0] EX_alu_out;
  logic            EX_true_taken;
  logic            EX_BP_taken;
  logic [PC_W-1:0] EX_BP_target_pc;
  logic            BP_flush;
  logic            F_BP_hit;
  logic            F_BP_taken;
  logic [PC_W-1:0] F_BP_target_pc;
  logic            EX_mispredict;

  modport master (
    output F_pc, F_stall, MEM_stall, EX_brn, EX_pc, EX_alu_out,
           EX_true_taken, EX_BP_taken, EX_BP_target_pc, BP_flush,
    input  F_BP_hit, F_BP_taken, F_BP_target_pc, EX_mispredict
  );

  modport slave (
    input  F_pc, F_stall, MEM_stall, EX_brn, EX_pc, EX_alu_out,
           EX_true_taken, EX_BP_taken, EX_BP_target_pc, BP_flush,
    output F_BP_hit, F_BP_taken, F_BP_target_pc, EX_mispredict
  );
endinterface

// File: rtl/bp_match.sv
// Priority CAM: compares a query PC against every valid tag and reports the
// lowest matching index.
module bp_match #(
  parameter int PC_W  = 5,
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [PC_W-1:0]          tags [DEPTH],
  input  logic [PC_W-1:0]          query,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] idx
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match[gi] = valid[gi] && (tags[gi] == query);
    end
  endgenerate

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/branch_target_buffer_2bit.sv
// IF-stage branch target buffer with 2-bit direction counters, fill-first
// round-robin replacement, flush, and EX-stage mispredict detection.
module branch_target_buffer_2bit
  import bp_pkg::*;
#(
  parameter int PC_W  = 5,
  parameter int DEPTH = 8
) (
  input logic                        clk,
  input logic                        rst,
  branch_target_buffer_2bit_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_reg;
  logic [PC_W-1:0]  tag_reg    [DEPTH];
  logic [PC_W-1:0]  target_reg [DEPTH];
  ctr_t             ctr_reg    [DEPTH];
  logic [IDX_W-1:0] vptr_reg;

  logic             f_hit;
  logic [IDX_W-1:0] f_idx;
  logic             ex_hit;
  logic [IDX_W-1:0] ex_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] alloc_idx;
  logic             upd;
  logic             f_inc;

  bp_match #(.PC_W(PC_W), .DEPTH(DEPTH)) u_match_f (
    .valid (valid_reg),
    .tags  (tag_reg),
    .query (bus.F_pc),
    .hit   (f_hit),
    .idx   (f_idx)
  );

  bp_match #(.PC_W(PC_W), .DEPTH(DEPTH)) u_match_ex (
    .valid (valid_reg),
    .tags  (tag_reg),
    .query (bus.EX_pc),
    .hit   (ex_hit),
    .idx   (ex_idx)
  );

  // Lowest-index invalid entry, same priority scan as the CAM.
  always_comb begin
    free_found = ~&valid_reg;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_reg[i]) free_idx = IDX_W'(i);
    end
  end

  assign alloc_idx = free_found ? free_idx : vptr_reg;
  assign upd       = bus.EX_brn && !bus.MEM_stall;
  assign f_inc     = !bus.F_stall && !bus.MEM_stall;

  // Lookup reads the registered table only, so same-cycle updates are not bypassed.
  always_comb begin
    bus.F_BP_hit       = f_hit;
    bus.F_BP_taken     = f_hit && ctr_taken(ctr_reg[f_idx]);
    bus.F_BP_target_pc = bus.F_BP_taken ? target_reg[f_idx]
                                        : bus.F_pc + PC_W'(f_inc);
  end

  always_comb begin
    bus.EX_mispredict = bus.EX_brn &&
                        ((bus.EX_BP_taken != bus.EX_true_taken) ||
                         (bus.EX_true_taken && (bus.EX_BP_target_pc != bus.EX_alu_out)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      vptr_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= WNT;
      end
    end else if (bus.BP_flush) begin
      valid_reg <= '0;
    end else if (upd) begin
      if (ex_hit) begin
        ctr_reg[ex_idx] <= bus.EX_true_taken ? ctr_inc(ctr_reg[ex_idx])
                                             : ctr_dec(ctr_reg[ex_idx]);
        if (bus.EX_true_taken) target_reg[ex_idx] <= bus.EX_alu_out;
      end else begin
        valid_reg[alloc_idx]  <= 1'b1;
        tag_reg[alloc_idx]    <= bus.EX_pc;
        target_reg[alloc_idx] <= bus.EX_alu_out;
        ctr_reg[alloc_idx]    <= ctr_init(bus.EX_true_taken);
        // Victim pointer only moves when it actually chose the slot.
        if (!free_found) vptr_reg <= vptr_reg + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer_2bit.sv
// Randomised plus directed bench for branch_target_buffer_2bit with a
// queue-based scoreboard against an entry-list reference model.
module tb_branch_target_buffer_2bit;
  localparam int PC_W  = 5;
  localparam int DEPTH = 8;
  localparam int MODV  = 1 << PC_W;

  typedef struct {
    bit rst;
    int f_pc;
    bit f_stall;
    bit mem_stall;
    bit brn;
    int ex_pc;
    int alu;
    bit true_taken;
    bit bp_taken;
    int bp_tgt;
    bit flush;
  } txn_t;

  typedef struct {
    int id;
    bit hit;
    bit taken;
    int tgt;
    bit mis;
  } exp_t;

  typedef struct {
    bit v;
    int tag;
    int tgt;
    int cnt;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_target_buffer_2bit_if #(.PC_W(PC_W)) bus ();

  branch_target_buffer_2bit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t m [DEPTH];
  int   m_vptr;
  exp_t exp_q [$];
  exp_t mon_e;
  txn_t prev;
  int   checks   = 0;
  int   failures = 0;
  int   txn_id   = 0;

  function automatic txn_t blank(input int fpc);
    txn_t t;
    t.rst = 0; t.f_pc = fpc; t.f_stall = 0; t.mem_stall = 0; t.brn = 0;
    t.ex_pc = 0; t.alu = 0; t.true_taken = 0; t.bp_taken = 0; t.bp_tgt = 0;
    t.flush = 0;
    return t;
  endfunction

  function automatic txn_t exb(input int pc, input int alu, input bit tk, input int fpc);
    txn_t t = blank(fpc);
    t.brn = 1; t.ex_pc = pc; t.alu = alu; t.true_taken = tk;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '{v: 0, tag: 0, tgt: 0, cnt: 1};
    m_vptr = 0;
  endtask

  function automatic int m_find(input int pc);
    for (int i = 0; i < DEPTH; i++) if (m[i].v && m[i].tag == pc) return i;
    return -1;
  endfunction

  // Apply the effect of one rising edge given the inputs held during the cycle.
  task automatic model_commit(input txn_t t);
    int h;
    int slot;
    if (t.rst) return;
    if (t.flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 0;
      return;
    end
    if (!t.brn || t.mem_stall) return;
    h = m_find(t.ex_pc);
    if (h >= 0) begin
      m[h].cnt = t.true_taken ? ((m[h].cnt < 3) ? m[h].cnt + 1 : 3)
                              : ((m[h].cnt > 0) ? m[h].cnt - 1 : 0);
      if (t.true_taken) m[h].tgt = t.alu;
    end else begin
      slot = -1;
      for (int i = 0; i < DEPTH && slot < 0; i++) if (!m[i].v) slot = i;
      if (slot < 0) begin
        slot   = m_vptr;
        m_vptr = (m_vptr + 1) % DEPTH;
      end
      m[slot] = '{v: 1, tag: t.ex_pc, tgt: t.alu, cnt: t.true_taken ? 2 : 1};
    end
  endtask

  function automatic exp_t predict(input txn_t t, input int id);
    exp_t e;
    int h = m_find(t.f_pc);
    e.id    = id;
    e.hit   = (h >= 0);
    e.taken = e.hit && (m[h].cnt >= 2);
    e.tgt   = e.taken ? m[h].tgt : (t.f_pc + ((!t.f_stall && !t.mem_stall) ? 1 : 0)) % MODV;
    if (!t.brn)                            e.mis = 0;
    else if (t.bp_taken != t.true_taken)   e.mis = 1;
    else if (t.true_taken && t.bp_tgt != t.alu) e.mis = 1;
    else                                   e.mis = 0;
    return e;
  endfunction

  task automatic step(input txn_t t);
    @(posedge clk);
    model_commit(prev);
    #1;
    rst                 = t.rst;
    bus.F_pc            = PC_W'(t.f_pc);
    bus.F_stall         = t.f_stall;
    bus.MEM_stall       = t.mem_stall;
    bus.EX_brn          = t.brn;
    bus.EX_pc           = PC_W'(t.ex_pc);
    bus.EX_alu_out      = PC_W'(t.alu);
    bus.EX_true_taken   = t.true_taken;
    bus.EX_BP_taken     = t.bp_taken;
    bus.EX_BP_target_pc = PC_W'(t.bp_tgt);
    bus.BP_flush        = t.flush;
    if (t.rst) model_reset();
    exp_q.push_back(predict(t, txn_id));
    txn_id++;
    prev = t;
  endtask

  // Monitor: outputs are combinational, so each cycle presents one response.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks += 4;
        if (bus.F_BP_hit !== mon_e.hit) begin
          failures++;
          $display("FAIL hit txn=%0d got=%0b exp=%0b", mon_e.id, bus.F_BP_hit, mon_e.hit);
        end
        if (bus.F_BP_taken !== mon_e.taken) begin
          failures++;
          $display("FAIL taken txn=%0d got=%0b exp=%0b", mon_e.id, bus.F_BP_taken, mon_e.taken);
        end
        if (bus.F_BP_target_pc !== PC_W'(mon_e.tgt)) begin
          failures++;
          $display("FAIL target txn=%0d got=%0d exp=%0d", mon_e.id, bus.F_BP_target_pc, mon_e.tgt);
        end
        if (bus.EX_mispredict !== mon_e.mis) begin
          failures++;
          $display("FAIL mispredict txn=%0d got=%0b exp=%0b", mon_e.id, bus.EX_mispredict, mon_e.mis);
        end
        $display("txn %0d: F_pc=%0d hit=%0b taken=%0b tgt=%0d mis=%0b", mon_e.id,
                 bus.F_pc, bus.F_BP_hit, bus.F_BP_taken, bus.F_BP_target_pc, bus.EX_mispredict);
      end
    end
  end

  initial begin
    txn_t t;
    model_reset();
    prev = blank(0);
    prev.rst = 1;

    // Lookup while in reset, then out of reset with stall and wrap variations.
    t = blank(3); t.rst = 1; step(t);
    t = blank(3); step(t);
    t = blank(3); t.f_stall = 1; step(t);
    t = blank(31); step(t);

    // Allocate, observe, then weaken.
    step(exb(6, 20, 1, 6));
    step(blank(6));
    step(exb(6, 20, 0, 6));
    step(blank(6));

    // Saturation in both directions.
    for (int i = 0; i < 4; i++) step(exb(6, 20, 1, 6));
    step(exb(6, 20, 0, 6));
    step(blank(6));
    for (int i = 0; i < 6; i++) step(exb(6, 20, 0, 6));
    step(blank(6));

    // Fill, then round-robin replacement.
    t = blank(0); t.rst = 1; step(t);
    for (int i = 0; i < 8; i++) step(exb(i, i + 16, 1, i));
    step(exb(9, 25, 1, 0));
    step(blank(0));
    step(exb(10, 26, 1, 1));
    step(blank(1));
    step(blank(9));

    // Flush with concurrent branch, then refill from slot 0.
    t = exb(12, 3, 1, 2); t.flush = 1; step(t);
    for (int i = 0; i < 4; i++) step(blank(i));
    step(blank(12));
    step(exb(12, 3, 1, 12));
    step(blank(12));

    // Mispredict cases, then MEM_stall holding a branch for three cycles.
    t = exb(12, 14, 1, 12); t.bp_taken = 1; t.bp_tgt = 12; step(t);
    t = exb(12, 14, 1, 12); t.bp_taken = 1; t.bp_tgt = 14; step(t);
    for (int i = 0; i < 3; i++) begin
      t = exb(12, 14, 0, 12); t.mem_stall = 1; step(t);
    end
    step(exb(12, 14, 0, 12));
    step(blank(12));

    // Asynchronous reset landing on an active update.
    t = exb(12, 5, 0, 12); t.rst = 1; step(t);
    step(blank(12));

    // Randomised traffic over a small PC range to exercise hits and eviction.
    for (int n = 0; n < 1500; n++) begin
      t = blank($urandom_range(0, 15));
      t.f_stall    = ($urandom_range(0, 3) == 0);
      t.mem_stall  = ($urandom_range(0, 3) == 0);
      t.brn        = ($urandom_range(0, 2) != 0);
      t.ex_pc      = $urandom_range(0, 11);
      t.alu        = $urandom_range(0, MODV - 1);
      t.true_taken = $urandom_range(0, 1);
      t.bp_taken   = $urandom_range(0, 1);
      t.bp_tgt     = $urandom_range(0, 1) ? t.alu : $urandom_range(0, MODV - 1);
      t.flush      = ($urandom_range(0, 40) == 0);
      t.rst        = ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 2) == 0) t.f_pc = t.ex_pc;
      step(t);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer_2bit.md
Name: branch_target_buffer_2bit

Overview:
Parametrised branch target buffer for the IF stage, replacing the single-bit FIFO predictor.
- Adds valid bits, 2-bit saturating direction counters, round-robin replacement that fills invalid entries first, a flush input, stall-gated updates, and an EX-stage mispredict flag.
- Fetch looks up F_pc combinationally. Execute updates or allocates on resolved branches.

Parameters:
PC_W, 5, PC / target width in bits
DEPTH, 8, number of entries (power of two, >=2)
IDX_W, $clog2(DEPTH), entry index width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
F_pc  in  PC_W  fetch PC
F_stall  in  1  fetch stall
MEM_stall  in  1  memory stall; freezes the sequential-PC increment and table updates
EX_brn  in  1  instruction in EX is a branch
EX_pc  in  PC_W  PC of EX branch
EX_alu_out  in  PC_W  resolved branch target
EX_true_taken  in  1  resolved direction
EX_BP_taken  in  1  prediction made at fetch, piped to EX
EX_BP_target_pc  in  PC_W  predicted next PC, piped to EX
BP_flush  in  1  invalidate all entries
F_BP_hit  out  1  valid entry matches F_pc
F_BP_taken  out  1  predicted taken
F_BP_target_pc  out  PC_W  predicted next PC
EX_mispredict  out  1  EX branch prediction was wrong

Behaviour:
State per entry:
- valid (1), tag pc (PC_W), target (PC_W), ctr (2).
- Global state: victim pointer vptr (IDX_W).

Reset (async, rst=1):
- All valid=0, ctr=WNT (01), tags/targets=0, vptr=0.
- Outputs while and after reset: F_BP_hit=0, F_BP_taken=0, F_BP_target_pc=F_pc+inc.

Fetch lookup (combinational, zero latency):
- Hit = any valid entry with tag==F_pc. On multiple matches the lowest index wins.
- F_BP_taken = hit & ctr[1].
- F_BP_target_pc = F_BP_taken ? target : F_pc + inc, where inc = !F_stall & !MEM_stall. Addition wraps modulo 2^PC_W.

EX mispredict (combinational):
- EX_mispredict = EX_brn & ((EX_BP_taken != EX_true_taken) | (EX_true_taken & EX_BP_target_pc != EX_alu_out)).
- Forced 0 when EX_brn=0.

Update (posedge), enable upd = EX_brn & !MEM_stall. Priority order:
1. BP_flush: all valid<=0; vptr, tags, targets and ctrs unchanged; any concurrent update is dropped.
2. upd & EX hit (valid tag==EX_pc, lowest index):
   - ctr saturating: +1 if EX_true_taken, -1 otherwise; clamps at 11 and 00.
   - If EX_true_taken, target<=EX_alu_out; otherwise target is unchanged.
3. upd & miss, allocate:
   - Slot = lowest-index invalid entry if any exist; otherwise vptr.
   - Write valid=1, tag=EX_pc, target=EX_alu_out, ctr = EX_true_taken ? WT(10) : WNT(01).
   - vptr advances to slot+1, wrapping DEPTH-1 -> 0, only when the slot came from vptr.

Boundary conditions:
- Same-cycle fetch and EX on the same PC: fetch sees the pre-update contents (no bypass). The new value is visible the next cycle.
- Full table: replacement is pure round-robin via vptr.
- Allocation after a flush refills from index 0 upward.
- MEM_stall=1 holds the whole table, so a stalled branch is counted once.
- rst asserted mid-update: the asynchronous clear wins and the update is lost.

Decomposition:
- Package bp_pkg holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - functions ctr_inc / ctr_dec (saturating)
  - function ctr_init(taken)
- Sub-module bp_match (parameters PC_W, DEPTH): priority CAM taking the valid vector, tag array and query PC; outputs hit and idx.
  - Instantiated twice: fetch-side and EX-side.
  - First-free-slot search reuses the same priority encoder style.

Test Plan:
1. Reset, then F_pc=3, no stalls -> F_BP_hit=0, F_BP_taken=0, F_BP_target_pc=4. With F_stall=1 -> target 3. With F_pc=31, no stalls -> target 0 (wrap).
2. EX_brn, EX_pc=6, EX_alu_out=20, taken -> next cycle F_pc=6 gives hit=1, taken=1, target=20 (ctr=10). A second not-taken update -> ctr=01, taken=0, target=7.
3. Saturation: four taken updates on pc 6 -> ctr=11. Then one not-taken -> 10, still predicts taken. Four not-taken updates -> ctr=00, further not-taken updates stay at 00.
4. Replacement: allocate PCs 0..7 (slots 0..7, vptr=0). Allocate pc 9 -> slot 0 evicted, F_pc=0 misses, vptr=1. Allocate pc 10 -> slot 1 evicted.
5. BP_flush and EX_brn together -> no entry valid after the edge, F_BP_hit=0 for all PCs. The next allocation lands in slot 0.
6. Mispredict and stall:
   - EX_BP_taken=1, EX_BP_target_pc=12, EX_true_taken=1, EX_alu_out=14 -> EX_mispredict=1. Matching target 14 -> 0.
   - EX_brn with MEM_stall=1 for 3 cycles -> table unchanged. Counter moves exactly once when the stall drops.
